// File: rtl/keccak_pkg.sv
// Shared constants, FSM state type and lane helpers for the Keccak theta blocks.
package keccak_pkg;

  localparam int NUM_LANES = 25;
  localparam int NUM_COLS  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    DRAIN = 3'd2,
    CALC  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Column (x) coordinate of a lane index 5*y + x.
  function automatic logic [2:0] lane_x(input logic [4:0] idx);
    return 3'(idx % 5'd5);
  endfunction

  // Left rotate by one within the low w bits; bits at and above w come back zero.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int z = 0; z < 64; z++) begin
      if (z < w) r[z] = v[(z + w - 1) % w];
    end
    return r;
  endfunction

endpackage

// File: rtl/theta_d_calc.sv
// Combinational theta D term: D[x] = C[x-1] ^ rotl1(C[x+1]), indices wrapping mod 5.
module theta_d_calc
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [NUM_COLS*LANE_W-1:0] i_c,
  output logic [NUM_COLS*LANE_W-1:0] o_d
);

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    localparam int XM = (gi + NUM_COLS - 1) % NUM_COLS;
    localparam int XP = (gi + 1) % NUM_COLS;

    assign o_d[gi*LANE_W +: LANE_W] = i_c[XM*LANE_W +: LANE_W]
                                    ^ LANE_W'(rotl1(64'(i_c[XP*LANE_W +: LANE_W]), LANE_W));
  end

endmodule

// File: rtl/keccak_theta.sv
// Column parity / in-place theta over a 25-lane state held in an external dual-port RAM.
module keccak_theta
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  output logic                       finish,
  output logic                       busy,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [LANE_W-1:0]          mem_rdata,
  output logic                       mem_wr_en,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [LANE_W-1:0]          mem_wdata,
  output logic [NUM_COLS*LANE_W-1:0] parity
);

  state_t                     r_state;
  logic                       r_start;
  logic                       r_mode;
  logic                       r_finish;
  logic                       r_busy;
  logic                       r_rd_en;
  logic                       r_wr_en;
  logic                       r_rv;
  logic [ADDR_W-1:0]          r_rd_addr;
  logic [ADDR_W-1:0]          r_wr_addr;
  logic [ADDR_W-1:0]          r_raddr_d;
  logic [4:0]                 r_cnt;
  logic [LANE_W-1:0]          r_c [NUM_COLS];
  logic [NUM_COLS*LANE_W-1:0] r_d;

  logic                       w_accept;
  logic [2:0]                 w_rx;
  logic [2:0]                 w_wx;
  logic [NUM_COLS*LANE_W-1:0] w_c;
  logic [NUM_COLS*LANE_W-1:0] w_d;
  logic [LANE_W-1:0]          w_d_sel;

  assign w_accept = start & ~r_start & (r_state == IDLE);
  assign w_rx     = lane_x(5'(r_raddr_d));
  assign w_wx     = lane_x(5'(r_wr_addr));

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_pack
    assign w_c[gi*LANE_W +: LANE_W] = r_c[gi];
  end

  theta_d_calc #(.LANE_W(LANE_W)) u_theta_d_calc (
    .i_c (w_c),
    .o_d (w_d)
  );

  always_comb begin
    w_d_sel = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (w_wx == 3'(i)) w_d_sel = r_d[i*LANE_W +: LANE_W];
    end
  end

  // Write data is formed from the lane returning this cycle so each write lands one
  // cycle after its read; gating on the write strobe keeps it at zero otherwise.
  assign mem_wdata = r_wr_en ? (mem_rdata ^ w_d_sel) : '0;

  // Lanes of row y=0 load their column, later rows fold in, so parity holds until then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COLS; i++) r_c[i] <= '0;
    end else if (r_rv) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (w_rx == 3'(i)) begin
          r_c[i] <= (r_raddr_d < ADDR_W'(NUM_COLS)) ? mem_rdata : (r_c[i] ^ mem_rdata);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_mode    <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rv      <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_raddr_d <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
    end else begin
      r_start   <= start;
      r_finish  <= 1'b0;
      r_rv      <= r_rd_en && (r_state == RD);
      r_raddr_d <= r_rd_addr;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RD;
            r_mode    <= mode;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_cnt     <= '0;
          end
        end
        RD: begin
          if (r_cnt == 5'd24) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= DRAIN;
          end else begin
            r_cnt     <= r_cnt + 5'd1;
            r_rd_addr <= ADDR_W'(r_cnt + 5'd1);
          end
        end
        DRAIN: r_state <= CALC;
        CALC: begin
          r_d <= w_d;
          if (r_mode) begin
            r_state   <= WB;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_cnt     <= '0;
          end else begin
            r_state <= DONE;
          end
        end
        WB: begin
          r_cnt     <= r_cnt + 5'd1;
          r_wr_en   <= r_rd_en;
          r_wr_addr <= r_rd_addr;
          if (r_cnt < 5'd24) begin
            r_rd_addr <= ADDR_W'(r_cnt + 5'd1);
          end else begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end
          if (r_cnt == 5'd25) r_state <= DONE;
        end
        DONE: begin
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign finish      = r_finish;
  assign busy        = r_busy;
  assign mem_rd_en   = r_rd_en;
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign parity      = w_c;

endmodule

// File: tb/tb_keccak_theta.sv
// Bench for keccak_theta: 64-bit and 8-bit instances, each with its own dual-port RAM model.
module tb_keccak_theta;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode = 1'b0;
  logic start64 = 1'b0;
  logic start8 = 1'b0;
  always #5 clk = ~clk;

  logic         fin64, busy64, rden64, wren64;
  logic [4:0]   rda64, wra64;
  logic [63:0]  rdata64, wdata64;
  logic [319:0] par64;
  logic         fin8, busy8, rden8, wren8;
  logic [4:0]   rda8, wra8;
  logic [7:0]   rdata8, wdata8;
  logic [39:0]  par8;

  keccak_theta #(.LANE_W(64), .ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .mode(mode), .finish(fin64), .busy(busy64),
    .mem_rd_en(rden64), .mem_rd_addr(rda64), .mem_rdata(rdata64),
    .mem_wr_en(wren64), .mem_wr_addr(wra64), .mem_wdata(wdata64), .parity(par64)
  );

  keccak_theta #(.LANE_W(8), .ADDR_W(5)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode), .finish(fin8), .busy(busy8),
    .mem_rd_en(rden8), .mem_rd_addr(rda8), .mem_rdata(rdata8),
    .mem_wr_en(wren8), .mem_wr_addr(wra8), .mem_wdata(wdata8), .parity(par8)
  );

  logic [63:0] img [25];
  logic [63:0] mem64 [25];
  logic [63:0] mem8 [25];
  logic        load64 = 1'b0;
  logic        load8 = 1'b0;
  int          wcnt64 = 0;
  int          wcnt8 = 0;

  always @(posedge clk) begin
    if (load64) begin
      for (int i = 0; i < 25; i++) mem64[i] <= img[i];
      wcnt64 <= 0;
    end else if (wren64) begin
      if (wra64 < 5'd25) mem64[wra64] <= wdata64;
      wcnt64 <= wcnt64 + 1;
    end
    if (rden64 && rda64 < 5'd25) rdata64 <= mem64[rda64];
  end

  always @(posedge clk) begin
    if (load8) begin
      for (int i = 0; i < 25; i++) mem8[i] <= {56'd0, img[i][7:0]};
      wcnt8 <= 0;
    end else if (wren8) begin
      if (wra8 < 5'd25) mem8[wra8] <= {56'd0, wdata8};
      wcnt8 <= wcnt8 + 1;
    end
    if (rden8 && rda8 < 5'd25) rdata8 <= mem8[rda8][7:0];
  end

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_c [5];
  logic [63:0] exp_m [25];

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  // Reference: column parity, D from neighbouring columns, then lane ^= D[x] when m=1.
  task automatic ref_model(input int w, input bit m);
    logic [63:0] msk, cp;
    logic [63:0] dd [5];
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int x = 0; x < 5; x++) begin
      exp_c[x] = '0;
      for (int y = 0; y < 5; y++) exp_c[x] = exp_c[x] ^ (img[5*y + x] & msk);
    end
    for (int x = 0; x < 5; x++) begin
      cp = exp_c[(x + 1) % 5];
      dd[x] = exp_c[(x + 4) % 5] ^ (((cp << 1) | (cp >> (w - 1))) & msk);
    end
    for (int i = 0; i < 25; i++) exp_m[i] = (img[i] & msk) ^ (m ? dd[i % 5] : 64'd0);
  endtask

  function automatic logic [319:0] pack_c(input int w);
    logic [319:0] r;
    r = '0;
    for (int x = 0; x < 5; x++) r = r | (320'(exp_c[x]) << (x * w));
    return r;
  endfunction

  task automatic load(input bit sel);
    @(negedge clk);
    if (sel) load8 = 1'b1; else load64 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    load64 = 1'b0;
  endtask

  task automatic check_mem(input bit sel, input string tag);
    for (int i = 0; i < 25; i++)
      chk($sformatf("%s_lane%0d", tag, i), sel ? mem8[i] : mem64[i], exp_m[i]);
  endtask

  task automatic rand_img();
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
  endtask

  task automatic clr_img();
    for (int i = 0; i < 25; i++) img[i] = '0;
  endtask

  // One run: raise start, follow 70 cycles counted from the accept edge.
  task automatic run(input bit sel, input bit m, input int hold, input int edge2,
                     output int fcyc, output int nfin);
    fcyc = -1;
    nfin = 0;
    @(negedge clk);
    mode = m;
    if (sel) start8 = 1'b1; else start64 = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("busy_rise", sel ? busy8 : busy64, 1'b1);
      if (cyc == hold - 1 || cyc == edge2 + 2) begin start64 = 1'b0; start8 = 1'b0; end
      if (cyc == edge2) begin if (sel) start8 = 1'b1; else start64 = 1'b1; end
      if (sel ? fin8 : fin64) begin
        nfin++;
        if (fcyc < 0) fcyc = cyc;
      end
    end
    chk("busy_end", sel ? busy8 : busy64, 1'b0);
    $display("run dut%0d mode=%0d: finish cycle %0d, finishes %0d", sel ? 8 : 64, m, fcyc, nfin);
  endtask

  int fc, nf;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl64", {fin64, busy64, rden64, wren64, rda64, wra64}, '0);
    chk("rst_wdata64", wdata64, '0);
    chk("rst_parity64", par64, '0);
    chk("rst_ctl8", {fin8, busy8, rden8, wren8, rda8, wra8, wdata8, par8}, '0);
    rst = 1'b1;

    // All-zero state, full theta
    clr_img(); ref_model(64, 1'b1); load(1'b0);
    run(1'b0, 1'b1, 1, -100, fc, nf);
    chk("zero_fin_cyc", fc, 54); chk("zero_nfin", nf, 1);
    chk("zero_parity", par64, '0); chk("zero_wcnt", wcnt64, 25);
    check_mem(1'b0, "zero");

    // Single bit in lane 1
    clr_img(); img[1] = 64'h1; ref_model(64, 1'b1); load(1'b0);
    run(1'b0, 1'b1, 1, -100, fc, nf);
    chk("l1_parity", par64, pack_c(64));
    chk("l1_x0", mem64[0], 64'h2); chk("l1_x0y3", mem64[15], 64'h2);
    chk("l1_lane1", mem64[1], 64'h1); chk("l1_x2", mem64[2], 64'h1);
    chk("l1_x3", mem64[3], 64'h0); chk("l1_x1y1", mem64[6], 64'h0);
    check_mem(1'b0, "l1");

    // 8-bit lanes, rotation wrap of bit 7
    clr_img(); img[4] = 64'h80; ref_model(8, 1'b1); load(1'b1);
    run(1'b1, 1'b1, 1, -100, fc, nf);
    chk("w8_fin_cyc", fc, 54);
    chk("w8_parity", 320'(par8), pack_c(8));
    chk("w8_x3", mem8[3], 64'h01); chk("w8_x3y1", mem8[8], 64'h01);
    chk("w8_x0", mem8[0], 64'h80); chk("w8_lane4", mem8[4], 64'h80);
    check_mem(1'b1, "w8");

    // Random state, parity only
    rand_img(); ref_model(64, 1'b0); load(1'b0);
    run(1'b0, 1'b0, 1, -100, fc, nf);
    chk("m0_fin_cyc", fc, 28); chk("m0_nfin", nf, 1);
    chk("m0_parity", par64, pack_c(64)); chk("m0_wcnt", wcnt64, 0);
    check_mem(1'b0, "m0");

    // Random states, full theta
    for (int t = 0; t < 2; t++) begin
      rand_img(); ref_model(64, 1'b1); load(1'b0);
      run(1'b0, 1'b1, 1, -100, fc, nf);
      chk("rnd_fin_cyc", fc, 54); chk("rnd_parity", par64, pack_c(64));
      check_mem(1'b0, "rnd");
    end

    // Start held 3 cycles, second edge during WB
    rand_img(); ref_model(64, 1'b1); load(1'b0);
    run(1'b0, 1'b1, 3, 35, fc, nf);
    chk("hold_nfin", nf, 1); chk("hold_fin_cyc", fc, 54);
    check_mem(1'b0, "hold");

    // Reset during WB while lane 10 is being read
    rand_img(); load(1'b0);
    @(negedge clk); mode = 1'b1; start64 = 1'b1;
    nf = 0;
    for (int cyc = 0; cyc <= 37; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start64 = 1'b0;
      if (fin64) nf++;
    end
    chk("abort_rd_addr", rda64, 5'd10);
    chk("abort_wr", {wren64, wra64}, {1'b1, 5'd9});
    rst = 1'b0;
    #1;
    chk("abort_ctl", {fin64, busy64, rden64, wren64, rda64, wra64}, '0);
    chk("abort_wdata", wdata64, '0); chk("abort_parity", par64, '0);
    @(negedge clk); @(negedge clk);
    chk("abort_nfin", nf + int'(fin64), 0);
    rst = 1'b1;
    rand_img(); ref_model(64, 1'b1); load(1'b0);
    run(1'b0, 1'b1, 1, -100, fc, nf);
    chk("post_fin_cyc", fc, 54); chk("post_parity", par64, pack_c(64));
    check_mem(1'b0, "post");

    // Back-to-back: restart in the first IDLE cycle after DONE
    rand_img(); ref_model(64, 1'b0); load(1'b0);
    @(negedge clk); mode = 1'b0; start64 = 1'b1;
    fc = -1;
    for (int cyc = 0; cyc < 40 && fc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start64 = 1'b0;
      if (fin64) begin fc = cyc; start64 = 1'b1; end
    end
    chk("b2b_first_fin", fc, 28);
    @(negedge clk);
    chk("b2b_restart_busy", busy64, 1'b1);
    start64 = 1'b0;
    fc = -1;
    for (int cyc = 0; cyc < 40 && fc < 0; cyc++) begin
      @(negedge clk);
      if (fin64) fc = cyc + 1;
    end
    chk("b2b_second_fin", fc, 28);
    chk("b2b_parity", par64, pack_c(64));
    $display("run back-to-back mode=0: second finish cycle %0d", fc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
